// File: rtl/shift_left_logic_seq.sv
// Multi-cycle logical-left shifter (SLL/SLLV) for the EX stage.
// Shifts up to STEP bits per clock under a start/busy/done handshake with ALU-style flags.
module shift_left_logic_seq #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] T,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] Y_lo,
  output logic        C,
  output logic        V,
  output logic        N,
  output logic        Z
);

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [W-1:0]  acc;
  logic [SW-1:0] rem;

  logic [SW-1:0] step_c;
  logic [W:0]    wide_c;
  logic [SW-1:0] rem_nxt_c;

  // One shift step; bit W of the widened result is the last bit shifted out of bit 31.
  always_comb begin
    step_c    = (rem < SW'(STEP)) ? rem : SW'(STEP);
    wide_c    = {1'b0, acc} << step_c;
    rem_nxt_c = rem - step_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Y_lo  <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
      N     <= 1'b0;
      Z     <= 1'b1;
    end else begin
      done <= 1'b0;
      V    <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc <= T;
            rem <= shamt;
            if (shamt == '0) begin
              // Zero shift completes immediately with the operand unchanged and no carry.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              Y_lo  <= T;
              C     <= 1'b0;
              N     <= T[W-1];
              Z     <= (T == '0);
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= wide_c[W-1:0];
          rem <= rem_nxt_c;
          if (rem_nxt_c == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Y_lo  <= wide_c[W-1:0];
            C     <= wide_c[W];
            N     <= wide_c[W-1];
            Z     <= (wide_c[W-1:0] == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_logic_seq.sv
// Directed self-checking bench for shift_left_logic_seq with STEP=1 and STEP=4 instances.
module tb_shift_left_logic_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] T = '0;
  logic [4:0]  shamt = '0;

  logic        busy1, done1, c1, v1, n1, z1;
  logic [31:0] y1;
  logic        busy4, done4, c4, v4, n4, z4;
  logic [31:0] y4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_left_logic_seq #(.STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .T(T), .shamt(shamt),
    .busy(busy1), .done(done1), .Y_lo(y1), .C(c1), .V(v1), .N(n1), .Z(z1)
  );

  shift_left_logic_seq #(.STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .T(T), .shamt(shamt),
    .busy(busy4), .done(done4), .Y_lo(y4), .C(c4), .V(v4), .N(n4), .Z(z4)
  );

  // Runs one operation on the selected instance; lat = cycles after the accept edge until done (-1 on timeout).
  task automatic do_op(input int inst, input logic [31:0] t, input logic [4:0] sh,
                       output int lat, output int bcnt, output logic [31:0] y,
                       output logic c, output logic n, output logic z, output logic v);
    @(posedge clk); #1;
    T = t; shamt = sh;
    if (inst == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    T = ~t; shamt = ~sh;
    lat = -1; bcnt = 0; y = '0; c = 1'b0; n = 1'b0; z = 1'b0; v = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (inst == 4) begin
        if (busy4) bcnt++;
        if (done4) begin lat = i; y = y4; c = c4; n = n4; z = z4; v = v4; break; end
      end else begin
        if (busy1) bcnt++;
        if (done1) begin lat = i; y = y1; c = c1; n = n1; z = z1; v = v1; break; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b1; start4 = 1'b1; T = 32'hDEADBEEF; shamt = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got=%b exp=0", done1); end
      checks++; if (y1 !== 32'h0) begin errors++; $display("FAIL reset_y1 got=%h exp=00000000", y1); end
      checks++; if ({z1, c1, n1, v1} !== 4'b1000) begin errors++; $display("FAIL reset_flags1 got=%b exp=1000", {z1, c1, n1, v1}); end
      checks++; if ({busy4, done4, z4, c4} !== 4'b0010 || y4 !== 32'h0) begin
        errors++; $display("FAIL reset_inst4 got=%b/%h exp=0010/00000000", {busy4, done4, z4, c4}, y4);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; start1 = 1'b0; start4 = 1'b0;
  endtask

  task automatic test_step1_basic();
    int lat, bc; logic [31:0] y; logic c, n, z, v;
    do_op(1, 32'h80000001, 5'd1, lat, bc, y, c, n, z, v);
    checks++; if (lat !== 2) begin errors++; $display("FAIL s1_lat got=%0d exp=2", lat); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL s1_busy got=%0d exp=1", bc); end
    checks++; if (y !== 32'h00000002) begin errors++; $display("FAIL s1_y got=%h exp=00000002", y); end
    checks++; if ({c, n, z, v} !== 4'b1000) begin errors++; $display("FAIL s1_flags got=%b exp=1000", {c, n, z, v}); end
    do_op(1, 32'h12345678, 5'd0, lat, bc, y, c, n, z, v);
    checks++; if (lat !== 1) begin errors++; $display("FAIL s0_lat got=%0d exp=1", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL s0_busy got=%0d exp=0", bc); end
    checks++; if (y !== 32'h12345678) begin errors++; $display("FAIL s0_y got=%h exp=12345678", y); end
    checks++; if ({c, n, z, v} !== 4'b0000) begin errors++; $display("FAIL s0_flags got=%b exp=0000", {c, n, z, v}); end
  endtask

  task automatic test_step1_long();
    int lat, bc; logic [31:0] y; logic c, n, z, v;
    do_op(1, 32'h00000001, 5'd31, lat, bc, y, c, n, z, v);
    checks++; if (lat !== 32) begin errors++; $display("FAIL s31_lat got=%0d exp=32", lat); end
    checks++; if (bc !== 31) begin errors++; $display("FAIL s31_busy got=%0d exp=31", bc); end
    checks++; if (y !== 32'h80000000) begin errors++; $display("FAIL s31_y got=%h exp=80000000", y); end
    checks++; if ({c, n, z} !== 3'b010) begin errors++; $display("FAIL s31_flags got=%b exp=010", {c, n, z}); end
    do_op(1, 32'hFFFFFFFF, 5'd4, lat, bc, y, c, n, z, v);
    checks++; if (lat !== 5) begin errors++; $display("FAIL s4_lat got=%0d exp=5", lat); end
    checks++; if (y !== 32'hFFFFFFF0) begin errors++; $display("FAIL s4_y got=%h exp=FFFFFFF0", y); end
    checks++; if ({c, n, z} !== 3'b110) begin errors++; $display("FAIL s4_flags got=%b exp=110", {c, n, z}); end
  endtask

  task automatic test_step4();
    int lat, bc; logic [31:0] y; logic c, n, z, v;
    do_op(4, 32'h0F000001, 5'd5, lat, bc, y, c, n, z, v);
    checks++; if (lat !== 3) begin errors++; $display("FAIL st4_lat got=%0d exp=3", lat); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL st4_busy got=%0d exp=2", bc); end
    checks++; if (y !== 32'hE0000020) begin errors++; $display("FAIL st4_y got=%h exp=E0000020", y); end
    checks++; if ({c, n, z, v} !== 4'b1100) begin errors++; $display("FAIL st4_flags got=%b exp=1100", {c, n, z, v}); end
  endtask

  task automatic test_start_in_shift();
    int lat = -1;
    int extra = 0;
    logic [31:0] y = '0;
    @(posedge clk); #1;
    T = 32'h00000003; shamt = 5'd3; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 1) begin T = 32'hFFFFFFFF; shamt = 5'd0; start1 = 1'b1; end
      else start1 = 1'b0;
      @(negedge clk);
      if (done1) begin
        if (lat < 0) begin lat = i; y = y1; end
        else extra++;
      end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ign_lat got=%0d exp=4", lat); end
    checks++; if (y !== 32'h00000018) begin errors++; $display("FAIL ign_y got=%h exp=00000018", y); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ign_queued got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat_a = -1;
    int lat_b = -1;
    logic [31:0] ya = '1;
    logic [31:0] yb = '1;
    logic [2:0] fa = '0;
    logic cb = 1'b1;
    @(posedge clk); #1;
    T = 32'h80000000; shamt = 5'd1; start1 = 1'b1;
    @(posedge clk); #1;
    T = 32'h00000005; shamt = 5'd2;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done1 && lat_a < 0) begin lat_a = i; ya = y1; fa = {z1, c1, n1}; end
      else if (done1 && lat_b < 0) begin lat_b = i; yb = y1; cb = c1; end
      @(posedge clk); #1;
      if (lat_a > 0) start1 = 1'b0;
    end
    checks++; if (lat_a !== 2) begin errors++; $display("FAIL b2b_lat_a got=%0d exp=2", lat_a); end
    checks++; if (ya !== 32'h0) begin errors++; $display("FAIL b2b_y_a got=%h exp=00000000", ya); end
    checks++; if (fa !== 3'b110) begin errors++; $display("FAIL b2b_flags_a got=%b exp=110", fa); end
    checks++; if (lat_b !== 5) begin errors++; $display("FAIL b2b_lat_b got=%0d exp=5", lat_b); end
    checks++; if (yb !== 32'h00000014 || cb !== 1'b0) begin
      errors++; $display("FAIL b2b_y_b got=%h/%b exp=00000014/0", yb, cb);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    int lat, bc; logic [31:0] y; logic c, n, z, v;
    @(posedge clk); #1;
    T = 32'h0000FFFF; shamt = 5'd20; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) reset = 1'b1;
      @(negedge clk);
      if (done1) seen++;
      if (i == 6) begin
        checks++; if ({busy1, done1, z1, c1, n1} !== 5'b00100 || y1 !== 32'h0) begin
          errors++; $display("FAIL abort_state got=%b/%h exp=00100/00000000", {busy1, done1, z1, c1, n1}, y1);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", seen); end
    do_op(1, 32'h00000001, 5'd2, lat, bc, y, c, n, z, v);
    checks++; if (lat !== 3 || y !== 32'h00000004) begin
      errors++; $display("FAIL abort_next got=%0d/%h exp=3/00000004", lat, y);
    end
  endtask

  initial begin
    test_reset();
    test_step1_basic();
    test_step1_long();
    test_step4();
    test_start_in_shift();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
